bus_sequencer: RTL

BUS_SEQUENCER -- requirements
Module: bus_sequencer

---
 rtl/bus_seq_pkg.sv | 45 ++++
 rtl/bus_seq_if.sv | 40 ++++
 rtl/bus_seq_timing.sv | 64 ++++++
 rtl/bus_sequencer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/bus_seq_pkg.sv
// bus_seq_pkg: slot boundaries and slot type for the 16-count bus sequencer.
// Shared by bus_seq_timing and bus_sequencer; no ports.
`timescale 1ns/1ps
package bus_seq_pkg;

   localparam logic [3:0] CNT_GUARD0     = 4'd0;
   localparam logic [3:0] CNT_VID_LAST   = 4'd3;
   localparam logic [3:0] CNT_SPI_FIRST  = 4'd4;
   localparam logic [3:0] CNT_SPI_LAST   = 4'd7;
   localparam logic [3:0] CNT_GUARD1     = 4'd8;
   localparam logic [3:0] CNT_CPU_FIRST  = 4'd9;
   localparam logic [3:0] CNT_PHI2_FIRST = 4'd11;
   localparam logic [3:0] CNT_PHI2_LAST  = 4'd14;
   localparam logic [3:0] CNT_SPI2_FIRST = 4'd9;

   typedef enum logic [2:0] {
      GUARD0,
      VIDEO,
      SPI,
      GUARD1,
      CPU,
      SPI2
   } slot_t;

   function automatic slot_t slot_of(
      input logic [3:0] cnt,
      input logic       stall
   );
      slot_t s;
      if (cnt == CNT_GUARD0)
         s = GUARD0;
      else if (cnt <= CNT_VID_LAST)
         s = VIDEO;
      else if (cnt <= CNT_SPI_LAST)
         s = SPI;
      else if (cnt == CNT_GUARD1)
         s = GUARD1;
      else if (stall)
         s = SPI2;
      else
         s = CPU;
      return s;
   endfunction

endpackage

// File: rtl/bus_seq_if.sv
// bus_seq_if: SPI requester handshake and shared memory bus signals.
// master = sequencer side, slave = requester/memory side.
`timescale 1ns/1ps
interface bus_seq_if;

   logic        spi_req_i;
   logic [16:0] spi_addr_i;
   logic        spi_we_i;
   logic [7:0]  spi_wr_data_i;
   logic [7:0]  spi_rd_data_o;
   logic        spi_busy_o;
   logic        spi_done_o;

   logic [16:0] bus_addr_o;
   logic        bus_addr_oe;
   logic [7:0]  bus_data_i;
   logic [7:0]  bus_data_o;
   logic        bus_data_oe;
   logic        bus_rw_no;
   logic        bus_rw_noe;

   modport master (
      input  spi_req_i, spi_addr_i, spi_we_i,
      input  spi_wr_data_i, bus_data_i,
      output spi_rd_data_o, spi_busy_o, spi_done_o,
      output bus_addr_o, bus_addr_oe,
      output bus_data_o, bus_data_oe,
      output bus_rw_no, bus_rw_noe
   );

   modport slave (
      output spi_req_i, spi_addr_i, spi_we_i,
      output spi_wr_data_i, bus_data_i,
      input  spi_rd_data_o, spi_busy_o, spi_done_o,
      input  bus_addr_o, bus_addr_oe,
      input  bus_data_o, bus_data_oe,
      input  bus_rw_no, bus_rw_noe
   );

endinterface

// File: rtl/bus_seq_timing.sv
// bus_seq_timing: free 0..15 slot counter, slot decode, CPU enable/phi2.
// Ports: clk16_i, reset_ni, [cpu_stall_i with BUS_SEQ_CPU_STALL_EN],
// cnt_o, slot_o (current), slot_nx_o (next count), cpu_be_o, cpu_clk_o.
`timescale 1ns/1ps
module bus_seq_timing
   import bus_seq_pkg::*;
(
   input  logic       clk16_i,
   input  logic       reset_ni,
`ifdef BUS_SEQ_CPU_STALL_EN
   input  logic       cpu_stall_i,
`endif
   output logic [3:0] cnt_o,
   output slot_t      slot_o,
   output slot_t      slot_nx_o,
   output logic       cpu_be_o,
   output logic       cpu_clk_o
);

   logic [3:0] cnt_q, cnt_d;
   logic       stall_q;
   logic       be_q, be_d;
   logic       phi2_q, phi2_d;

   assign cnt_d = cnt_q + 4'd1;

`ifdef BUS_SEQ_CPU_STALL_EN
   // Decided on the edge entering GUARD1 so it is stable
   // for the whole 9..15 span it governs.
   always_ff @(posedge clk16_i or negedge reset_ni) begin
      if (!reset_ni)
         stall_q <= 1'b0;
      else if (cnt_q == CNT_GUARD1 - 4'd1)
         stall_q <= cpu_stall_i;
   end
`else
   assign stall_q = 1'b0;
`endif

   // CPU strobes are registered from the next count
   // so they leave the FPGA glitch-free.
   assign be_d   = (cnt_d >= CNT_CPU_FIRST) && !stall_q;
   assign phi2_d = (cnt_d >= CNT_PHI2_FIRST) &&
                   (cnt_d <= CNT_PHI2_LAST) && !stall_q;

   always_ff @(posedge clk16_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cnt_q  <= 4'd0;
         be_q   <= 1'b0;
         phi2_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         be_q   <= be_d;
         phi2_q <= phi2_d;
      end
   end

   assign cnt_o     = cnt_q;
   assign slot_o    = slot_of(cnt_q, stall_q);
   assign slot_nx_o = slot_of(cnt_d, stall_q);
   assign cpu_be_o  = be_q;
   assign cpu_clk_o = phi2_q;

endmodule

// File: rtl/bus_sequencer.sv
// bus_sequencer: time-slots one 8-bit bus between video, SPI and a CPU.
// Ports: clk16_i, reset_ni, video_*, cpu_be_o/cpu_clk_o, bus (bus_seq_if.master);
// macro BUS_SEQ_CPU_STALL_EN adds cpu_stall_i and a second SPI slot.
`timescale 1ns/1ps
module bus_sequencer
   import bus_seq_pkg::*;
(
   input  logic        clk16_i,
   input  logic        reset_ni,
`ifdef BUS_SEQ_CPU_STALL_EN
   input  logic        cpu_stall_i,
`endif
   input  logic [16:0] video_addr_i,
   output logic [7:0]  video_data_o,
   output logic        video_strobe_o,
   output logic        cpu_be_o,
   output logic        cpu_clk_o,
   bus_seq_if.master   bus
);

   logic [3:0] cnt;
   slot_t      slot, slot_nx;

   bus_seq_timing u_timing (
      .clk16_i   (clk16_i),
      .reset_ni  (reset_ni),
`ifdef BUS_SEQ_CPU_STALL_EN
      .cpu_stall_i (cpu_stall_i),
`endif
      .cnt_o     (cnt),
      .slot_o    (slot),
      .slot_nx_o (slot_nx),
      .cpu_be_o  (cpu_be_o),
      .cpu_clk_o (cpu_clk_o)
   );

   logic       spi_win, nx_win;
   logic       spi_cap, spi_last, wr_strb;
   logic [3:0] phase;

   assign spi_win  = (slot == SPI) || (slot == SPI2);
   assign nx_win   = (slot_nx == SPI) || (slot_nx == SPI2);
   assign spi_cap  = nx_win && !spi_win;
   assign spi_last = spi_win && !nx_win;

   // Offset inside the SPI window: 0 is address/data setup,
   // 1-2 the write strobe, the rest hold. The second window
   // simply holds longer so its read lands on count 15.
   assign phase   = cnt - ((slot == SPI2) ? CNT_SPI2_FIRST
                                          : CNT_SPI_FIRST);
   assign wr_strb = (phase == 4'd1) || (phase == 4'd2);

   logic        pend_vld_q, pend_vld_d;
   logic        pend_we_q, pend_we_d;
   logic [16:0] pend_addr_q, pend_addr_d;
   logic [7:0]  pend_wd_q, pend_wd_d;
   logic        done_q, done_d;
   logic [7:0]  rd_q, rd_d;
   logic [7:0]  vid_q, vid_d;
   logic        vstb_q, vstb_d;
   logic        vid_last;

   assign vid_last = (slot == VIDEO) && (cnt == CNT_VID_LAST);

   always_comb begin
      pend_vld_d  = pend_vld_q;
      pend_we_d   = pend_we_q;
      pend_addr_d = pend_addr_q;
      pend_wd_d   = pend_wd_q;
      if (spi_cap) begin
         pend_vld_d  = bus.spi_req_i;
         pend_we_d   = bus.spi_we_i;
         pend_addr_d = bus.spi_addr_i;
         pend_wd_d   = bus.spi_wr_data_i;
      end else if (spi_last) begin
         pend_vld_d  = 1'b0;
      end
      done_d = spi_last && pend_vld_q;
      rd_d   = rd_q;
      if (done_d && !pend_we_q)
         rd_d = bus.bus_data_i;
      vid_d  = vid_last ? bus.bus_data_i : vid_q;
      vstb_d = vid_last;
   end

   always_ff @(posedge clk16_i or negedge reset_ni) begin
      if (!reset_ni) begin
         pend_vld_q  <= 1'b0;
         pend_we_q   <= 1'b0;
         pend_addr_q <= '0;
         pend_wd_q   <= '0;
         done_q      <= 1'b0;
         rd_q        <= '0;
         vid_q       <= '0;
         vstb_q      <= 1'b0;
      end else begin
         pend_vld_q  <= pend_vld_d;
         pend_we_q   <= pend_we_d;
         pend_addr_q <= pend_addr_d;
         pend_wd_q   <= pend_wd_d;
         done_q      <= done_d;
         rd_q        <= rd_d;
         vid_q       <= vid_d;
         vstb_q      <= vstb_d;
      end
   end

   // Everything outside VIDEO and a live SPI window leaves
   // the bus undriven, so the CPU never collides with us.
   always_comb begin
      bus.bus_addr_o  = '0;
      bus.bus_addr_oe = 1'b0;
      bus.bus_data_o  = '0;
      bus.bus_data_oe = 1'b0;
      bus.bus_rw_no   = 1'b1;
      bus.bus_rw_noe  = 1'b0;
      unique case (1'b1)
         (slot == VIDEO): begin
            bus.bus_addr_o  = video_addr_i;
            bus.bus_addr_oe = 1'b1;
            bus.bus_rw_noe  = 1'b1;
         end
         (spi_win && pend_vld_q): begin
            bus.bus_addr_o  = pend_addr_q;
            bus.bus_addr_oe = 1'b1;
            bus.bus_rw_noe  = 1'b1;
            if (pend_we_q) begin
               bus.bus_data_o  = pend_wd_q;
               bus.bus_data_oe = 1'b1;
               bus.bus_rw_no   = !wr_strb;
            end
         end
         default: ;
      endcase
   end

   assign bus.spi_rd_data_o = rd_q;
   assign bus.spi_busy_o    = pend_vld_q || done_q;
   assign bus.spi_done_o    = done_q;
   assign video_data_o      = vid_q;
   assign video_strobe_o    = vstb_q;

endmodule
